// File: rtl/menshen_pkg.sv
// -----------------------------------------------------------------------------
// menshen_pkg -- constants and helpers shared across the Menshen pipeline.
//
// Contents:
//   PHV_LEN_DEFAULT  default packet-header-vector width in bits
//   NUM_OUT_QUEUES   number of per-queue outputs of the last stage
//   fifo_op_e        write/pop combination seen by a FIFO in one cycle
//   sat_inc32()      saturating 32-bit increment for statistics counters
// -----------------------------------------------------------------------------
package menshen_pkg;

    localparam int PHV_LEN_DEFAULT = 1024;
    localparam int NUM_OUT_QUEUES  = 4;

    // Bit 1 = write accepted, bit 0 = pop performed.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/phv_fifo_ram.sv
// -----------------------------------------------------------------------------
// phv_fifo_ram -- simple dual-port storage for phv_out_fifo.
// One write port, one read port with a registered read. The read register is
// the FIFO's output register, so it is reset (to all zeros) while the array
// itself is never reset.
//
// A read of the address being written in the same cycle returns the new
// write data. phv_out_fifo relies on this only when the FIFO holds nothing
// behind the output register, which is the one case where both addresses can
// coincide.
//
// Ports:
//   clk      clock, rising edge
//   resetn   synchronous active-low reset of the read register
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_en    load the read register from rd_addr
//   rd_addr  read address
//   rd_data  registered read data, held while rd_en is low
// -----------------------------------------------------------------------------
module phv_fifo_ram #(
    parameter int W     = 1024,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Storage array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read with write-through on address collision.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/phv_out_fifo.sv
// -----------------------------------------------------------------------------
// phv_out_fifo -- first-word-fall-through PHV buffer between the last pipeline
// stage and the deparser, one instance per output queue.
//
// The head entry sits in the registered read port of phv_fifo_ram; entries
// behind it live in the array between rd_ptr and wr_ptr. occupancy counts both.
// Writes are accepted whenever there is room (or a pop frees room the same
// cycle) regardless of phv_fifo_ready, which is only an early warning leaving
// AFULL_MARGIN free slots for PHVs already in flight.
//
// Optional feature: define PHV_FIFO_STATS_EN to add the drop_cnt port, a
// saturating count of PHVs dropped because the FIFO was full.
//
// Ports:
//   axis_clk        clock, rising edge
//   aresetn         synchronous active-low reset
//   phv_in          incoming PHV
//   phv_in_valid    phv_in is valid this cycle
//   phv_fifo_ready  upstream may keep sending (registered, advisory)
//   phv_out         head PHV toward the deparser (registered)
//   phv_out_valid   phv_out holds a valid entry (registered)
//   phv_out_ready   deparser accepts phv_out this cycle
//   occupancy       stored entries including the head (registered)
//   drop_cnt        overflow drop count (PHV_FIFO_STATS_EN only)
// -----------------------------------------------------------------------------
module phv_out_fifo
    import menshen_pkg::*;
#(
    parameter int PHV_LEN      = PHV_LEN_DEFAULT,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                    axis_clk,
    input  logic                    aresetn,
    input  logic [PHV_LEN-1:0]      phv_in,
    input  logic                    phv_in_valid,
    output logic                    phv_fifo_ready,
    output logic [PHV_LEN-1:0]      phv_out,
    output logic                    phv_out_valid,
    input  logic                    phv_out_ready,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef PHV_FIFO_STATS_EN
    ,
    output logic [31:0]             drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [OW-1:0] OCC_ONE   = OW'(1);
    localparam logic [OW-1:0] OCC_FULL  = OW'(DEPTH);
    localparam logic          READY_RST = (AFULL_MARGIN < DEPTH) ? 1'b1 : 1'b0;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic          out_valid;
    logic          ready;

    logic          pop;
    logic          full;
    logic          wr;
    logic          load;
    logic [OW-1:0] mem_cnt;
    logic [OW-1:0] occ_next;
    logic          ready_next;
    fifo_op_e      op;

    // Handshake decode, occupancy update and head-register load decision.
    always_comb begin
        pop     = out_valid && phv_out_ready;
        full    = (occ == OCC_FULL);
        wr      = phv_in_valid && (!full || pop);
        // Entries in the array, i.e. not yet moved into the head register.
        mem_cnt = occ - {{AW{1'b0}}, out_valid};
        // Refill the head whenever it is empty or leaving and something is
        // available, including a PHV arriving this very cycle.
        load    = (!out_valid || pop) && ((mem_cnt != {OW{1'b0}}) || wr);
        op      = fifo_op_e'({wr, pop});
        case (op)
            OP_IDLE:  occ_next = occ;
            OP_RD:    occ_next = occ - OCC_ONE;
            OP_WR:    occ_next = occ + OCC_ONE;
            OP_WR_RD: occ_next = occ;
            default:  occ_next = occ;
        endcase
        ready_next = ((int'(occ_next) + AFULL_MARGIN) < DEPTH);
    end

    // Pointers, occupancy, head-valid flag and almost-full flag.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            wr_ptr    <= {AW{1'b0}};
            rd_ptr    <= {AW{1'b0}};
            occ       <= {OW{1'b0}};
            out_valid <= 1'b0;
            ready     <= READY_RST;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            occ   <= occ_next;
            ready <= ready_next;
            if (load) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    phv_fifo_ram #(
        .W     (PHV_LEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (axis_clk),
        .resetn  (aresetn),
        .wr_en   (wr),
        .wr_addr (wr_ptr),
        .wr_data (phv_in),
        .rd_en   (load),
        .rd_addr (rd_ptr),
        .rd_data (phv_out)
    );

    assign phv_out_valid  = out_valid;
    assign phv_fifo_ready = ready;
    assign occupancy      = occ;

`ifdef PHV_FIFO_STATS_EN
    logic        drop;
    logic [31:0] drop_cnt_q;

    // A PHV is lost only when full and nothing leaves the same cycle.
    always_comb begin
        drop = phv_in_valid && full && !pop;
    end

    // Saturating overflow-drop counter.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            drop_cnt_q <= 32'd0;
        end else if (drop) begin
            drop_cnt_q <= sat_inc32(drop_cnt_q);
        end else begin
            drop_cnt_q <= drop_cnt_q;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_phv_out_fifo.sv
// -----------------------------------------------------------------------------
// tb_phv_out_fifo -- directed self-checking bench for phv_out_fifo
// (DEPTH=16, AFULL_MARGIN=2, 64-bit PHVs). Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge in between.
// -----------------------------------------------------------------------------
module tb_phv_out_fifo;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [W-1:0] phv_in = 64'd0;
    logic         phv_in_valid = 1'b0;
    logic         phv_fifo_ready;
    logic [W-1:0] phv_out;
    logic         phv_out_valid;
    logic         phv_out_ready = 1'b0;
    logic [4:0]   occupancy;
`ifdef PHV_FIFO_STATS_EN
    logic [31:0]  drop_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] exp_d;
    logic [W-1:0] d;
    int           drop_m;
    logic         rdy;
    logic         pop_m;

    always #5 clk = ~clk;

    phv_out_fifo #(
        .PHV_LEN      (W),
        .DEPTH        (16),
        .AFULL_MARGIN (2)
    ) dut (
        .axis_clk       (clk),
        .aresetn        (aresetn),
        .phv_in         (phv_in),
        .phv_in_valid   (phv_in_valid),
        .phv_fifo_ready (phv_fifo_ready),
        .phv_out        (phv_out),
        .phv_out_valid  (phv_out_valid),
        .phv_out_ready  (phv_out_ready),
        .occupancy      (occupancy)
`ifdef PHV_FIFO_STATS_EN
        ,
        .drop_cnt       (drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop everything the model holds, checking order and content.
    task automatic drain(input int bound);
        phv_in_valid  = 1'b0;
        phv_out_ready = 1'b1;
        for (int i = 0; i < bound && q.size() > 0; i++) begin
            chk("drain_valid", {63'd0, phv_out_valid}, 64'd1);
            exp_d = q.pop_front();
            chk("drain_data", phv_out, exp_d);
            @(negedge clk);
        end
        chk("drain_occ", {59'd0, occupancy}, 64'd0);
        chk("drain_empty", {63'd0, phv_out_valid}, 64'd0);
        phv_out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_occ", {59'd0, occupancy}, 64'd0);
        chk("rst_valid", {63'd0, phv_out_valid}, 64'd0);
        chk("rst_data", phv_out, 64'd0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("rel_ready", {63'd0, phv_fifo_ready}, 64'd1);
        chk("rel_occ", {59'd0, occupancy}, 64'd0);
`ifdef PHV_FIFO_STATS_EN
        chk("rel_drop", {32'd0, drop_cnt}, 64'd0);
`endif

        // Single write with the deparser ready: appears next cycle, then leaves
        phv_out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            phv_in = 64'hA5;
            phv_in_valid = 1'b1;
            @(negedge clk);
            phv_in_valid = 1'b0;
            chk("a5_valid", {63'd0, phv_out_valid}, 64'd1);
            chk("a5_data", phv_out, 64'hA5);
            chk("a5_occ1", {59'd0, occupancy}, 64'd1);
            @(negedge clk);
            chk("a5_occ0", {59'd0, occupancy}, 64'd0);
            chk("a5_gone", {63'd0, phv_out_valid}, 64'd0);
        end
        phv_out_ready = 1'b0;

        // Fill to the almost-full threshold, then to full
        for (int i = 0; i < 16; i++) begin
            phv_in = 64'd100 + 64'(i);
            phv_in_valid = 1'b1;
            q.push_back(phv_in);
            @(negedge clk);
            if (i == 12) chk("afull_13_ready", {63'd0, phv_fifo_ready}, 64'd1);
            if (i == 13) chk("afull_14_ready", {63'd0, phv_fifo_ready}, 64'd0);
        end
        chk("full_occ", {59'd0, occupancy}, 64'd16);
        chk("full_head", phv_out, 64'd100);

        // Three writes into a full FIFO with no pop are dropped
        for (int i = 0; i < 3; i++) begin
            phv_in = 64'd200 + 64'(i);
            @(negedge clk);
        end
        chk("drop_occ", {59'd0, occupancy}, 64'd16);
        chk("drop_head", phv_out, 64'd100);
`ifdef PHV_FIFO_STATS_EN
        chk("drop_cnt3", {32'd0, drop_cnt}, 64'd3);
`endif

        // Full with simultaneous write and pop: write accepted
        phv_in = 64'd300;
        phv_out_ready = 1'b1;
        exp_d = q.pop_front();
        q.push_back(phv_in);
        @(negedge clk);
        phv_in_valid = 1'b0;
        phv_out_ready = 1'b0;
        chk("wrpop_occ", {59'd0, occupancy}, 64'd16);
        chk("wrpop_head", phv_out, 64'd101);
`ifdef PHV_FIFO_STATS_EN
        chk("wrpop_drop", {32'd0, drop_cnt}, 64'd3);
`endif
        drain(40);

        // Continuous writes with random deparser backpressure
        drop_m = 0;
        d = 64'h1000;
        phv_in_valid = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            rdy = 1'($urandom_range(0, 1));
            pop_m = (q.size() != 0) && rdy;
            if (pop_m) begin
                exp_d = q.pop_front();
                chk("rnd_data", phv_out, exp_d);
            end
            if (q.size() < 16) begin
                q.push_back(d);
            end else begin
                drop_m++;
            end
            phv_out_ready = rdy;
            phv_in = d;
            d = d + 64'd1;
            @(negedge clk);
            if ((c % 100) == 99) begin
                chk("rnd_occ", {59'd0, occupancy}, 64'(q.size()));
                chk("rnd_valid", {63'd0, phv_out_valid}, {63'd0, (q.size() != 0)});
            end
        end
`ifdef PHV_FIFO_STATS_EN
        chk("rnd_drop", {32'd0, drop_cnt}, 64'd3 + 64'(drop_m));
`endif
        drain(40);

        // Reset pulse with five entries stored
        phv_out_ready = 1'b0;
        phv_in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            phv_in = 64'h5000 + 64'(i);
            @(negedge clk);
        end
        phv_in_valid = 1'b0;
        chk("pre_rst_occ", {59'd0, occupancy}, 64'd5);
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        chk("mid_rst_occ", {59'd0, occupancy}, 64'd0);
        chk("mid_rst_valid", {63'd0, phv_out_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, phv_fifo_ready}, 64'd1);
        chk("mid_rst_data", phv_out, 64'd0);
        @(negedge clk);
        chk("post_rst_valid", {63'd0, phv_out_valid}, 64'd0);
        chk("post_rst_occ", {59'd0, occupancy}, 64'd0);
`ifdef PHV_FIFO_STATS_EN
        chk("post_rst_drop", {32'd0, drop_cnt}, 64'd0);
`endif
        phv_in = 64'hBEEF;
        phv_in_valid = 1'b1;
        @(negedge clk);
        phv_in_valid = 1'b0;
        chk("post_rst_head", phv_out, 64'hBEEF);
        chk("post_rst_occ1", {59'd0, occupancy}, 64'd1);
        @(negedge clk);
        chk("post_rst_hold", phv_out, 64'hBEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/phv_out_fifo.md
PHV_OUT_FIFO -- requirements
Module: phv_out_fifo

Interface
REQ-001 SHALL have parameter PHV_LEN, default 1024, PHV width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entries; power of two, 4..256.
REQ-003 SHALL have parameter AFULL_MARGIN, default 2, free entries reserved to absorb in-flight PHVs after ready drops.
REQ-004 SHALL have port axis_clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port aresetn, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port phv_in, input, PHV_LEN, PHV from the last stage's per-queue output.
REQ-007 SHALL have port phv_in_valid, input, 1, phv_in is valid this cycle.
REQ-008 SHALL have port phv_fifo_ready, output, 1, upstream may keep sending; advisory, with AFULL_MARGIN slack.
REQ-009 SHALL have port phv_out, output, PHV_LEN, head PHV toward the deparser.
REQ-010 SHALL have port phv_out_valid, output, 1, phv_out holds a valid head entry.
REQ-011 SHALL have port phv_out_ready, input, 1, deparser accepts phv_out this cycle.
REQ-012 SHALL have port occupancy, output, clog2(DEPTH)+1, stored entry count, including the output register.
REQ-013 SHALL have port drop_cnt, output, 32, overflow drop count; present only under REQ-032.

Function
REQ-014 SHALL accept a write on every cycle phv_in_valid=1 and occupancy<DEPTH, ignoring phv_fifo_ready.
REQ-015 SHALL drive phv_fifo_ready = (occupancy + AFULL_MARGIN < DEPTH), from registered state only.
REQ-016 SHALL drop phv_in when phv_in_valid=1, occupancy==DEPTH, and no read occurs that cycle.
REQ-017 SHALL accept the write when full if a read occurs the same cycle; occupancy stays DEPTH.
REQ-018 SHALL perform a read (pop) when phv_out_valid=1 and phv_out_ready=1.
REQ-019 SHALL be first-word-fall-through with a registered output: a write into an empty FIFO gives phv_out_valid=1 with that data the next cycle.
REQ-020 SHALL hold phv_out and phv_out_valid stable while phv_out_valid=1 and phv_out_ready=0.
REQ-021 SHALL, after a pop, present the next entry on the next cycle with no bubble when one is stored, else set phv_out_valid=0.
REQ-022 SHALL, on a simultaneous write and pop with occupancy==1, forward the written PHV into the output register the next cycle.
REQ-023 SHALL deliver accepted PHVs in order, unmodified, and never duplicate one.
REQ-024 SHALL wrap read/write pointers modulo DEPTH with no dead slot, using a separate count to tell full from empty.
REQ-025 SHALL update occupancy each cycle by +1 on write only, -1 on pop only, 0 on both or neither.
REQ-026 SHALL keep occupancy within 0..DEPTH.

Reset
REQ-027 SHALL, while aresetn=0 at a clock edge, clear both pointers, occupancy, phv_out_valid and phv_out to 0, and clear drop_cnt when present.
REQ-028 SHALL assert phv_fifo_ready=1 the first cycle after reset release.
REQ-029 SHALL discard all stored entries when reset is asserted mid-operation; no stale PHV may appear after release.
REQ-030 SHALL NOT reset the storage array contents.

Configuration
REQ-031 SHALL use macro PHV_FIFO_STATS_EN.
REQ-032 SHALL, with PHV_FIFO_STATS_EN defined, add drop_cnt: +1 per dropped PHV (REQ-016), saturating at 32'hFFFF_FFFF.
REQ-033 SHALL, without PHV_FIFO_STATS_EN, omit the drop_cnt port and counter logic; all other behaviour is identical.

Structure
REQ-034 SHALL take the PHV_LEN default and the queue-count constant (4) from the shared package menshen_pkg.
REQ-035 SHALL place storage in sub-module phv_fifo_ram: simple dual-port, 1 write and 1 read port, registered read, DEPTH x PHV_LEN.
REQ-036 SHALL be instantiated once per output queue, four instances per pipeline.

Verification
REQ-037 SHALL pass: reset, then one write of PHV 0xA5 repeated with phv_out_ready=1 -> phv_out_valid=1 with 0xA5 one cycle later, then occupancy returns to 0.
REQ-038 SHALL pass: 14 back-to-back writes with phv_out_ready=0, DEPTH=16, AFULL_MARGIN=2 -> phv_fifo_ready falls after the 14th write; 2 more writes accepted; occupancy=16.
REQ-039 SHALL pass: full FIFO, 3 more writes with phv_out_ready=0 -> all 3 dropped, drop_cnt=3, head unchanged.
REQ-040 SHALL pass: full FIFO, write and pop in the same cycle -> write accepted, occupancy=16, drop_cnt unchanged.
REQ-041 SHALL pass: continuous writes and random phv_out_ready for 1000 cycles -> output sequence equals accepted input sequence, no gaps or duplicates.
REQ-042 SHALL pass: aresetn pulsed low for 1 cycle with 5 entries stored -> next cycle occupancy=0, phv_out_valid=0, phv_fifo_ready=1.
